lsu_mem_port: RTL and testbench

Load/store initiator for the byte-addressed, word-wide main memory. Accepts one load or store request at a time from the pipeline's memory stage, drives the memory's `address`/`data_in`/`read_write` pins, and samples `data_out`. Sub-word stores use a read-modify-write sequence because the memory always writes all four bytes. Returns the sign- or zero-extended load data, or a completion pulse for stores.

---
 rtl/lsu_mem_port_if.sv | 32 +++
 rtl/lsu_mem_port.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// Request/response and memory-pin bundle for lsu_mem_port.
// The slave modport is the LSU's view; master is the pipeline plus memory side.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_data_in, mem_read_write,
        output mem_data_out
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_data_in, mem_read_write,
        input  mem_data_out
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator for word-wide memory; sub-word stores use
// read-modify-write. Define LSU_RANGE_CHECK_EN to reject addresses outside the memory window.
module lsu_mem_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter logic [31:0] DEPTH_BYTES = 32'h0010_0000
) (
    input logic           clock,
    input logic           reset_n,
    lsu_mem_port_if.slave bus
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic        mem_rw_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [31:0] req_word_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        req_error;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_word_addr = {bus.req_addr[31:2], 2'b00};

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'd1:    misaligned = bus.req_addr[0];
            2'd2:    misaligned = (bus.req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // With the check disabled this term folds to zero and no comparator remains.
    assign out_of_range = RangeCheck &&
        (({1'b0, req_word_addr} < {1'b0, BASE_ADDR}) ||
         ({1'b0, req_word_addr} >= ({1'b0, BASE_ADDR} + {1'b0, DEPTH_BYTES})));
    assign req_error = misaligned || out_of_range;

    always_comb begin
        load_byte = bus.mem_data_out[{off_q, 3'b000} +: 8];
        load_half = off_q[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        case (size_q)
            2'd0:    load_data = unsigned_q ? {24'b0, load_byte}
                                            : {{24{load_byte[7]}}, load_byte};
            2'd1:    load_data = unsigned_q ? {16'b0, load_half}
                                            : {{16{load_half[15]}}, load_half};
            default: load_data = bus.mem_data_out;
        endcase
    end

    // Replace only the target lanes of the word read during RD.
    always_comb begin
        merged = bus.mem_data_out;
        if (size_q == 2'd0) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_error_q  <= 1'b0;
            mem_address_q <= BASE_ADDR;
            mem_data_in_q <= 32'h0;
            mem_rw_q      <= 1'b0;
            write_q       <= 1'b0;
            size_q        <= 2'd0;
            unsigned_q    <= 1'b0;
            off_q         <= 2'd0;
            wdata_q       <= 16'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        off_q       <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata[15:0];
                        if (req_error) begin
                            state_q      <= StDone;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (bus.req_write && bus.req_size == 2'd2) begin
                            state_q       <= StWr;
                            mem_address_q <= req_word_addr;
                            mem_data_in_q <= bus.req_wdata;
                            mem_rw_q      <= 1'b1;
                        end else begin
                            state_q       <= StRd;
                            mem_address_q <= req_word_addr;
                        end
                    end
                end
                StRd: begin
                    if (write_q) begin
                        state_q       <= StWr;
                        mem_data_in_q <= merged;
                        mem_rw_q      <= 1'b1;
                    end else begin
                        state_q      <= StDone;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                StWr: begin
                    state_q      <= StDone;
                    mem_rw_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0;
                end
                StDone: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_data_in    = mem_data_in_q;
    assign bus.mem_read_write = mem_rw_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 16-word memory model at BASE.
module tb_lsu_mem_port;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lsu_mem_port_if bus ();

    lsu_mem_port #(
        .BASE_ADDR   (BASE),
        .DEPTH_BYTES (32'h0010_0000)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [16];
    logic        in_win;
    assign in_win = (bus.mem_address[31:6] == 26'h004_0000);
    assign bus.mem_data_out = in_win ? mem[bus.mem_address[5:2]] : 32'h0;

    // Memory ignores reset: it writes whenever WRITE is presented on an edge.
    always @(posedge clock) begin
        if (bus.mem_read_write && in_win) mem[bus.mem_address[5:2]] <= bus.mem_data_in;
    end

    int unsigned wr_cycles = 0;
    logic [31:0] last_wr_addr = 32'h0;
    always @(negedge clock) begin
        if (bus.mem_read_write) begin
            wr_cycles    <= wr_cycles + 1;
            last_wr_addr <= bus.mem_address;
        end
    end

    int checks = 0;
    int failures = 0;
    int r_lat;
    logic [31:0] r_rdata;
    logic r_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input logic w, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        handshake(w, sz, uns, addr, wd);
        r_lat   = 0;
        r_rdata = 32'hx;
        r_err   = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                r_lat   = k;
                r_rdata = bus.resp_rdata;
                r_err   = bus.resp_error;
                break;
            end
        end
    endtask

    task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, sz, uns, addr, 32'h0);
        check({tag, "_rdata"}, r_rdata, exp);
        check({tag, "_lat"}, 32'(r_lat), 32'd2);
        check({tag, "_err"}, 32'(r_err), 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input int exp_lat);
        int unsigned w0;
        w0 = wr_cycles;
        do_req(1'b1, sz, 1'b0, addr, wd);
        check({tag, "_lat"}, 32'(r_lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(r_err), 32'd0);
        check({tag, "_rdata"}, r_rdata, 32'd0);
        check({tag, "_writes"}, 32'(wr_cycles - w0), 32'd1);
        check({tag, "_wr_addr"}, last_wr_addr, {addr[31:2], 2'b00});
    endtask

    task automatic run_err(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] addr);
        int unsigned w0;
        w0 = wr_cycles;
        do_req(w, sz, 1'b0, addr, 32'hFFFF_FFFF);
        check({tag, "_err"}, 32'(r_err), 32'd1);
        check({tag, "_rdata"}, r_rdata, 32'd0);
        check({tag, "_lat"}, 32'(r_lat), 32'd1);
        check({tag, "_writes"}, 32'(wr_cycles - w0), 32'd0);
    endtask

    initial begin
        int unsigned w0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_error", 32'(bus.resp_error), 32'd0);
        check("rst_mem_address", bus.mem_address, BASE);
        check("rst_mem_data_in", bus.mem_data_in, 32'd0);
        check("rst_mem_rw", 32'(bus.mem_read_write), 32'd0);
        reset_n = 1'b1;

        run_store("sw_preload", 2'd2, BASE, 32'h8899_AABB, 2);
        run_load("lb", 2'd0, 1'b0, BASE + 1, 32'hFFFF_FFAA);
        run_load("lbu", 2'd0, 1'b1, BASE + 1, 32'h0000_00AA);
        run_load("lh", 2'd1, 1'b0, BASE + 2, 32'hFFFF_8899);
        run_load("lhu", 2'd1, 1'b1, BASE + 2, 32'h0000_8899);
        run_load("lw", 2'd2, 1'b0, BASE, 32'h8899_AABB);

        run_store("sb", 2'd0, BASE + 3, 32'h0000_0012, 3);
        run_load("lw_after_sb", 2'd2, 1'b0, BASE, 32'h1299_AABB);
        run_store("sw", 2'd2, BASE + 4, 32'hDEAD_BEEF, 2);
        run_load("lw_after_sw", 2'd2, 1'b0, BASE + 4, 32'hDEAD_BEEF);
        run_store("sh", 2'd1, BASE + 6, 32'hFFFF_1234, 3);
        run_load("lw_after_sh", 2'd2, 1'b0, BASE + 4, 32'h1234_BEEF);

        run_err("lh_mis", 1'b0, 2'd1, BASE + 1);
        run_err("lw_mis", 1'b0, 2'd2, BASE + 2);
        run_err("sw_mis", 1'b1, 2'd2, BASE + 5);
        run_err("size3", 1'b0, 2'd3, BASE);

`ifdef LSU_RANGE_CHECK_EN
        run_err("lw_oor", 1'b0, 2'd2, 32'h0200_0000);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h0200_0000, 32'h0);
        check("lw_oor_err", 32'(r_err), 32'd0);
        check("lw_oor_lat", 32'(r_lat), 32'd2);
        check("lw_oor_addr", bus.mem_address, 32'h0200_0000);
`endif

        // Reset during RD of a read-modify-write: nothing may be written.
        run_store("sw_w2", 2'd2, BASE + 8, 32'h1122_3344, 2);
        w0 = wr_cycles;
        handshake(1'b1, 2'd0, 1'b0, BASE + 8, 32'h0000_0055);
        @(negedge clock);
        check("rd_abort_rw", 32'(bus.mem_read_write), 32'd0);
        check("rd_abort_addr", bus.mem_address, BASE + 8);
        reset_n = 1'b0;
        @(negedge clock);
        check("rd_abort_ready", 32'(bus.req_ready), 32'd0);
        check("rd_abort_valid", 32'(bus.resp_valid), 32'd0);
        check("rd_abort_rst_rw", 32'(bus.mem_read_write), 32'd0);
        check("rd_abort_rst_addr", bus.mem_address, BASE);
        check("rd_abort_rst_din", bus.mem_data_in, 32'd0);
        reset_n = 1'b1;
        check("rd_abort_writes", 32'(wr_cycles - w0), 32'd0);
        run_load("lw_after_rd_abort", 2'd2, 1'b0, BASE + 8, 32'h1122_3344);

        // Reset on the edge ending WR: the write still lands, no response follows.
        handshake(1'b1, 2'd0, 1'b0, BASE + 8, 32'h0000_0055);
        @(negedge clock);
        check("wr_rst_rd_rw", 32'(bus.mem_read_write), 32'd0);
        @(negedge clock);
        check("wr_rst_wr_rw", 32'(bus.mem_read_write), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check("wr_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("wr_rst_rw", 32'(bus.mem_read_write), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("wr_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        run_load("lw_after_wr_rst", 2'd2, 1'b0, BASE + 8, 32'h1122_3355);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
